// File: rtl/ysyx_25060170_wbarb_if.sv
// Writeback arbiter bus: EXU and LSU result offers, flush, the
// register-file write port, the retire record and the retire counter.
interface ysyx_25060170_wbarb_if;
    // EXU writeback offer
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_rd_ena;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_data;
    logic [31:0] ex_pc;
    logic [31:0] ex_inst;
    // LSU load result offer
    logic        ls_valid;
    logic        ls_ready;
    logic        ls_rd_ena;
    logic [4:0]  ls_rd_addr;
    logic [31:0] ls_data;
    logic [31:0] ls_pc;
    logic [31:0] ls_inst;
    // trap / interrupt redirect
    logic        flush;
    // register-file write port and retire record
    logic        wb_rd_ena;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_inst;
    logic [31:0] retire_cnt;

    // The arbiter side
    modport slave (
        input  ex_valid, ex_rd_ena, ex_rd_addr, ex_data, ex_pc, ex_inst,
        input  ls_valid, ls_rd_ena, ls_rd_addr, ls_data, ls_pc, ls_inst,
        input  flush,
        output ex_ready, ls_ready,
        output wb_rd_ena, wb_rd_addr, wb_data, wb_valid, wb_pc, wb_inst,
        output retire_cnt
    );

    // The pipeline side that offers results and consumes the writeback
    modport master (
        output ex_valid, ex_rd_ena, ex_rd_addr, ex_data, ex_pc, ex_inst,
        output ls_valid, ls_rd_ena, ls_rd_addr, ls_data, ls_pc, ls_inst,
        output flush,
        input  ex_ready, ls_ready,
        input  wb_rd_ena, wb_rd_addr, wb_data, wb_valid, wb_pc, wb_inst,
        input  retire_cnt
    );
endinterface

// File: rtl/ysyx_25060170_wbarb.sv
// Writeback arbiter: picks one of the EXU / LSU results per cycle
// (LSU preferred, EXU promoted after STARVE_MAX consecutive refusals),
// registers the winner into a one-cycle writeback stage and counts
// retired instructions.
module ysyx_25060170_wbarb #(
    parameter int STARVE_MAX = 4   // legal range 1..15
) (
    input  logic                   clk,
    input  logic                   rst,   // asynchronous, active-low
    ysyx_25060170_wbarb_if.slave   bus
);

    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0]  r_starve_cnt;
    logic        w_starve_hit;
    logic        w_ex_grant;
    logic        w_ls_grant;
    logic        w_any_grant;

    logic        w_sel_rd_ena;
    logic [4:0]  w_sel_rd_addr;
    logic [31:0] w_sel_data;
    logic [31:0] w_sel_pc;
    logic [31:0] w_sel_inst;

    logic        r_wb_valid;
    logic        r_wb_rd_ena;
    logic [4:0]  r_wb_rd_addr;
    logic [31:0] r_wb_data;
    logic [31:0] r_wb_pc;
    logic [31:0] r_wb_inst;
    logic [31:0] r_retire_cnt;

    assign w_starve_hit = (r_starve_cnt == C_STARVE_MAX);
    assign w_any_grant  = w_ex_grant | w_ls_grant;

    // Combinational grant: LSU wins ties unless EXU has been starved long enough
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_ex_grant = 1'b0;
        w_ls_grant = 1'b0;
        if (rst && !bus.flush) begin
            if (bus.ex_valid && (!bus.ls_valid || w_starve_hit)) begin
                w_ex_grant = 1'b1;
            end else if (bus.ls_valid) begin
                w_ls_grant = 1'b1;
            end
        end
    end

    assign bus.ex_ready = w_ex_grant;
    assign bus.ls_ready = w_ls_grant;

    // Payload mux selecting the granted requester
    always_comb begin
        w_sel_rd_ena  = 1'b0;
        w_sel_rd_addr = '0;
        w_sel_data    = '0;
        w_sel_pc      = '0;
        w_sel_inst    = '0;
        if (w_ls_grant) begin
            w_sel_rd_ena  = bus.ls_rd_ena;
            w_sel_rd_addr = bus.ls_rd_addr;
            w_sel_data    = bus.ls_data;
            w_sel_pc      = bus.ls_pc;
            w_sel_inst    = bus.ls_inst;
        end else if (w_ex_grant) begin
            w_sel_rd_ena  = bus.ex_rd_ena;
            w_sel_rd_addr = bus.ex_rd_addr;
            w_sel_data    = bus.ex_data;
            w_sel_pc      = bus.ex_pc;
            w_sel_inst    = bus.ex_inst;
        end
    end

    // Count consecutive cycles EXU is offered but refused, saturating at STARVE_MAX
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (bus.flush || !bus.ex_valid || w_ex_grant) begin
            r_starve_cnt <= '0;
        end else if (!w_starve_hit) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Writeback stage: capture the granted record, or an all-zero bubble
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the payload registers are reset too, because an idle writeback must read as all zeros.
        if (!rst) begin
            r_wb_valid   <= 1'b0;
            r_wb_rd_ena  <= 1'b0;
            r_wb_rd_addr <= '0;
            r_wb_data    <= '0;
            r_wb_pc      <= '0;
            r_wb_inst    <= '0;
        end else if (w_any_grant) begin
            r_wb_valid   <= 1'b1;
            // x0 writes retire but never reach the register file
            r_wb_rd_ena  <= w_sel_rd_ena && (w_sel_rd_addr != 5'd0);
            r_wb_rd_addr <= w_sel_rd_addr;
            r_wb_data    <= w_sel_data;
            r_wb_pc      <= w_sel_pc;
            r_wb_inst    <= w_sel_inst;
        end else begin
            r_wb_valid   <= 1'b0;
            r_wb_rd_ena  <= 1'b0;
            r_wb_rd_addr <= '0;
            r_wb_data    <= '0;
            r_wb_pc      <= '0;
            r_wb_inst    <= '0;
        end
    end

    // Retire counter advances together with the record it counts, so it
    // already includes the instruction currently shown on wb_valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retire_cnt <= '0;
        end else if (w_any_grant) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign bus.wb_valid   = r_wb_valid;
    assign bus.wb_rd_ena  = r_wb_rd_ena;
    assign bus.wb_rd_addr = r_wb_rd_addr;
    assign bus.wb_data    = r_wb_data;
    assign bus.wb_pc      = r_wb_pc;
    assign bus.wb_inst    = r_wb_inst;
    assign bus.retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_ysyx_25060170_wbarb.sv
// Bench for the writeback arbiter: a behavioural model checked on every
// falling edge, plus directed scenarios with hand-computed expectations.
module tb_ysyx_25060170_wbarb;

    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ysyx_25060170_wbarb_if bus ();

    ysyx_25060170_wbarb #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef enum {G_NONE, G_EX, G_LS} grant_e;

    typedef struct packed {
        logic        valid;
        logic        rd_ena;
        logic [4:0]  rd_addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] inst;
    } rec_t;

    rec_t        m_rec;
    logic [31:0] m_retired;
    int          m_refused;   // consecutive cycles EXU was offered and turned away

    function automatic grant_e model_grant();
        if (!rst || bus.flush)                  return G_NONE;
        if (bus.ex_valid && bus.ls_valid)       return (m_refused == STARVE_MAX) ? G_EX : G_LS;
        if (bus.ex_valid)                       return G_EX;
        if (bus.ls_valid)                       return G_LS;
        return G_NONE;
    endfunction

    // Compare on the falling edge, then advance the model by the cycle's inputs
    always @(negedge clk) begin
        grant_e g;
        if (!rst) begin
            m_rec     = '0;
            m_retired = '0;
            m_refused = 0;
        end
        check("m_wb_valid",   bus.wb_valid,   m_rec.valid);
        check("m_wb_rd_ena",  bus.wb_rd_ena,  m_rec.rd_ena);
        check("m_wb_rd_addr", bus.wb_rd_addr, m_rec.rd_addr);
        check("m_wb_data",    bus.wb_data,    m_rec.data);
        check("m_wb_pc",      bus.wb_pc,      m_rec.pc);
        check("m_wb_inst",    bus.wb_inst,    m_rec.inst);
        check("m_retire_cnt", bus.retire_cnt, m_retired);
        g = model_grant();
        check("m_ex_ready", bus.ex_ready, g == G_EX);
        check("m_ls_ready", bus.ls_ready, g == G_LS);
        if (rst) begin
            case (g)
                G_EX: begin
                    m_rec = '{1'b1, bus.ex_rd_ena && bus.ex_rd_addr != 0, bus.ex_rd_addr,
                              bus.ex_data, bus.ex_pc, bus.ex_inst};
                    m_retired = m_retired + 1;
                end
                G_LS: begin
                    m_rec = '{1'b1, bus.ls_rd_ena && bus.ls_rd_addr != 0, bus.ls_rd_addr,
                              bus.ls_data, bus.ls_pc, bus.ls_inst};
                    m_retired = m_retired + 1;
                end
                default: m_rec = '0;
            endcase
            if (bus.flush || !bus.ex_valid || g == G_EX) m_refused = 0;
            else if (m_refused < STARVE_MAX)             m_refused = m_refused + 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_ex(input logic v, input logic ena, input logic [4:0] a,
                          input logic [31:0] d, input logic [31:0] pc, input logic [31:0] inst);
        bus.ex_valid = v; bus.ex_rd_ena = ena; bus.ex_rd_addr = a;
        bus.ex_data = d;  bus.ex_pc = pc;      bus.ex_inst = inst;
    endtask

    task automatic set_ls(input logic v, input logic ena, input logic [4:0] a,
                          input logic [31:0] d, input logic [31:0] pc, input logic [31:0] inst);
        bus.ls_valid = v; bus.ls_rd_ena = ena; bus.ls_rd_addr = a;
        bus.ls_data = d;  bus.ls_pc = pc;      bus.ls_inst = inst;
    endtask

    task automatic idle();
        set_ex(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        set_ls(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        bus.flush = 1'b0;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic        ex_v;
        logic        ls_v;
        logic        ena;
        logic [4:0]  addr;
        logic        exp_valid;
        logic        exp_rd_ena;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [8] = '{
        '{1'b1, 1'b0, 1'b1, 5'd3,  1'b1, 1'b1, 32'hE000_0000},
        '{1'b0, 1'b1, 1'b0, 5'd9,  1'b1, 1'b0, 32'h5000_0001},
        '{1'b1, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 32'hE000_0002},
        '{1'b0, 1'b0, 1'b1, 5'd4,  1'b0, 1'b0, 32'h0000_0000},
        '{1'b1, 1'b1, 1'b1, 5'd31, 1'b1, 1'b1, 32'h5000_0004},
        '{1'b0, 1'b1, 1'b1, 5'd1,  1'b1, 1'b1, 32'h5000_0005},
        '{1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 32'hE000_0006},
        '{1'b1, 1'b1, 1'b1, 5'd2,  1'b1, 1'b1, 32'h5000_0007}
    };

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid",   bus.wb_valid,   32'd0);
        check("rst_retire_cnt", bus.retire_cnt, 32'd0);
        rst = 1'b1;

        // Single EXU result
        set_ex(1'b1, 1'b1, 5'd5, 32'h0000_1234, 32'h8000_0000, 32'h0050_0093);
        #1;
        check("ex_only_ex_ready", bus.ex_ready, 32'd1);
        check("ex_only_ls_ready", bus.ls_ready, 32'd0);
        tick();
        idle();
        check("ex_only_wb_valid",  bus.wb_valid,   32'd1);
        check("ex_only_wb_rd_ena", bus.wb_rd_ena,  32'd1);
        check("ex_only_wb_rd",     bus.wb_rd_addr, 32'd5);
        check("ex_only_wb_data",   bus.wb_data,    32'h0000_1234);
        check("ex_only_wb_pc",     bus.wb_pc,      32'h8000_0000);
        check("ex_only_retire",    bus.retire_cnt, 32'd1);
        tick();
        check("bubble_wb_valid", bus.wb_valid,   32'd0);
        check("bubble_wb_data",  bus.wb_data,    32'd0);
        check("bubble_retire",   bus.retire_cnt, 32'd1);

        // LSU write to x0: retires without a register write
        set_ls(1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 32'h8000_0004, 32'h0000_2003);
        tick();
        idle();
        check("x0_wb_valid",  bus.wb_valid,   32'd1);
        check("x0_wb_rd_ena", bus.wb_rd_ena,  32'd0);
        check("x0_retire",    bus.retire_cnt, 32'd2);

        // Both held: four LSU grants, then EXU, repeating
        set_ex(1'b1, 1'b1, 5'd7, 32'hAAAA_0007, 32'h8000_0100, 32'h0070_0393);
        for (int i = 0; i < 10; i++) begin
            set_ls(1'b1, 1'b1, 5'(8 + i), 32'h0000_0100 + 32'(i), 32'h8000_0200 + 32'(4 * i), 32'h0000_3003);
            #1;
            check("starve_ex_ready", bus.ex_ready, 32'((i % 5) == 4));
            check("starve_ls_ready", bus.ls_ready, 32'((i % 5) != 4));
            tick();
        end

        // Two refusals, then a flush must clear the starvation count
        for (int i = 0; i < 2; i++) begin
            #1;
            check("preflush_ls_ready", bus.ls_ready, 32'd1);
            tick();
        end
        bus.flush = 1'b1;
        #1;
        check("flush_ex_ready", bus.ex_ready, 32'd0);
        check("flush_ls_ready", bus.ls_ready, 32'd0);
        tick();
        bus.flush = 1'b0;
        check("flush_wb_valid",  bus.wb_valid,  32'd0);
        check("flush_wb_rd_ena", bus.wb_rd_ena, 32'd0);
        for (int j = 0; j < 5; j++) begin
            #1;
            check("postflush_ex_ready", bus.ex_ready, 32'(j == 4));
            tick();
        end

        // Flush against a lone EXU offer
        set_ls(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        bus.flush = 1'b1;
        #1;
        check("flush_ex_alone_ready", bus.ex_ready, 32'd0);
        tick();
        bus.flush = 1'b0;
        check("flush_ex_alone_wb_valid", bus.wb_valid, 32'd0);
        idle();
        tick();

        // Back-to-back mixed vectors
        for (int i = 0; i < 8; i++) begin
            set_ex(vecs[i].ex_v, vecs[i].ena, vecs[i].addr, 32'hE000_0000 | 32'(i),
                   32'h8000_1000 + 32'(4 * i), 32'h0000_0013);
            set_ls(vecs[i].ls_v, vecs[i].ena, vecs[i].addr, 32'h5000_0000 | 32'(i),
                   32'h8000_2000 + 32'(4 * i), 32'h0000_2083);
            tick();
            check("vec_wb_valid",  bus.wb_valid,  32'(vecs[i].exp_valid));
            check("vec_wb_rd_ena", bus.wb_rd_ena, 32'(vecs[i].exp_rd_ena));
            check("vec_wb_data",   bus.wb_data,   vecs[i].exp_data);
        end
        idle();
        tick();

        // Asynchronous reset between edges drops the in-flight record
        set_ex(1'b1, 1'b1, 5'd6, 32'h0000_6666, 32'h8000_3000, 32'h0060_0313);
        tick();
        check("prerst_wb_valid", bus.wb_valid, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_wb_valid",  bus.wb_valid,   32'd0);
        check("async_rst_wb_rd_ena", bus.wb_rd_ena,  32'd0);
        check("async_rst_wb_data",   bus.wb_data,    32'd0);
        check("async_rst_wb_pc",     bus.wb_pc,      32'd0);
        check("async_rst_retire",    bus.retire_cnt, 32'd0);
        check("async_rst_ex_ready",  bus.ex_ready,   32'd0);
        tick();
        rst = 1'b1;
        #1;
        check("post_rst_ex_ready", bus.ex_ready, 32'd1);
        tick();
        check("post_rst_retire",  bus.retire_cnt, 32'd1);
        check("post_rst_wb_data", bus.wb_data,    32'h0000_6666);
        idle();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25060170_wbarb.md
YSYX_25060170_WBARB -- requirements
Module: ysyx_25060170_wbarb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive cycles EXU may be refused before it wins priority (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ex_valid  input  1  EXU result offered.
REQ-005 SHALL have port ex_ready  output  1  EXU result accepted this cycle.
REQ-006 SHALL have ports ex_rd_ena input 1, ex_rd_addr input 5, ex_data input 32, ex_pc input 32, ex_inst input 32  EXU writeback payload.
REQ-007 SHALL have port ls_valid  input  1  LSU load result offered.
REQ-008 SHALL have port ls_ready  output  1  LSU result accepted this cycle.
REQ-009 SHALL have ports ls_rd_ena input 1, ls_rd_addr input 5, ls_data input 32, ls_pc input 32, ls_inst input 32  LSU writeback payload.
REQ-010 SHALL have port flush  input  1  trap/interrupt redirect; discard all pending writeback.
REQ-011 SHALL have ports wb_rd_ena output 1, wb_rd_addr output 5, wb_data output 32  register-file write port.
REQ-012 SHALL have ports wb_valid output 1, wb_pc output 32, wb_inst output 32  retire record for the commit DPI.
REQ-013 SHALL have port retire_cnt  output  32  count of retired instructions.

Function
REQ-014 Grant SHALL be combinational: only one of ex_ready/ls_ready high per cycle; neither high while flush=1.
REQ-015 Only ex_valid=1 SHALL grant EXU; only ls_valid=1 SHALL grant LSU; neither valid SHALL grant none.
REQ-016 Both valid SHALL grant LSU, unless starve_cnt==STARVE_MAX, then grant EXU.
REQ-017 starve_cnt (4 bit) SHALL increment when ex_valid=1 and ex_ready=0, saturating at STARVE_MAX; clear when ex_ready=1, ex_valid=0, or flush=1.
REQ-018 The granted payload SHALL be registered into the output stage; outputs appear exactly 1 cycle after the handshake cycle.
REQ-019 wb_valid SHALL be 1 for one cycle per accepted handshake; 0 in cycles following no grant.
REQ-020 wb_rd_ena SHALL be wb_valid AND granted rd_ena AND rd_addr!=0 (x0 writes suppressed; record still retires).
REQ-021 When wb_valid=0, wb_rd_ena SHALL be 0; wb_rd_addr, wb_data, wb_pc and wb_inst SHALL be 0.
REQ-022 flush=1 SHALL force wb_valid=0 and wb_rd_ena=0 in the next cycle, regardless of any same-cycle request.
REQ-023 A handshake SHALL occur only when valid and ready are both high; a requester may hold valid across refused cycles with payload stable.
REQ-024 retire_cnt SHALL increment by 1 on every cycle that wb_valid=1; wraps 0xFFFFFFFF -> 0; not cleared by flush.
REQ-025 Back-to-back grants SHALL be sustained: one retire per cycle with no bubbles while any request is valid.

Reset
REQ-026 rst=0 SHALL immediately (asynchronously) clear wb_valid, wb_rd_ena, wb_rd_addr, wb_data, wb_pc, wb_inst, retire_cnt and starve_cnt to 0.
REQ-027 While rst=0, ex_ready and ls_ready SHALL be 0; a handshake in flight when reset asserts SHALL be dropped.
REQ-028 After rst deassertion, the first grant SHALL follow REQ-015/016 with starve_cnt=0.

Verification
REQ-029 ex_valid=1, rd=5, data=0x1234, pc=0x80000000 only -> ex_ready=1 same cycle; next cycle wb_valid=1, wb_rd_ena=1, wb_rd_addr=5, wb_data=0x1234, retire_cnt=1.
REQ-030 ex_valid and ls_valid both held high, STARVE_MAX=4 -> LSU granted 4 cycles, EXU on the 5th, starve_cnt back to 0; pattern repeats.
REQ-031 ls_valid=1, ls_rd_addr=0, ls_rd_ena=1 -> next cycle wb_valid=1, wb_rd_ena=0; retire_cnt increments.
REQ-032 flush=1 with both requests valid -> ex_ready=ls_ready=0; next cycle wb_valid=0; starve_cnt=0.
REQ-033 retire_cnt preloaded to 0xFFFFFFFF via retirements, one more retire -> retire_cnt=0.
REQ-034 rst driven low mid-stream between clock edges -> all outputs 0 before next edge; after release, retire_cnt restarts from 0.
